// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared fetch-pipeline constants, fetch FSM encodings and the buffered entry layout.
package inst_prefetch_buffer_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// prefetch_fifo: synchronous FIFO of {pc, inst} entries with a single-cycle flush.
// Latency: a write is visible at the head the cycle after; head reads as zero when empty.
// Backpressure: none internally; a write while full is dropped unless a read frees the slot.
module prefetch_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  entry_t                     wr_dat_i,
    input  logic                       rd_en_i,
    output entry_t                     rd_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_wr, do_rd;

    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == CNT_W'(DEPTH));
    assign count_o  = cnt_q;
    assign do_rd    = rd_en_i & ~empty_o;
    assign do_wr    = wr_en_i & (~full_o | do_rd);
    assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Decoupled in-order instruction prefetcher with redirect flush; PREFETCH_BYPASS_EN adds same-cycle forwarding.
// Latency: response to head in 1 cycle (0 cycles through the bypass when the buffer is empty).
// Backpressure: requests are throttled so buffered + outstanding never exceeds DEPTH, and outstanding never exceeds MAX_OUTST.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        deq_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_pcplus_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] stale_q, stale_d;

    logic       in_fetch, acc, rv_live, rv_stale, byp;
    logic       fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_cnt;
    entry_t     fifo_wdat, fifo_head, head;
    logic       unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc_i[1:0];

    assign in_fetch = (state_q == ST_FETCH);
    assign rv_live  = mem_rvalid_i & in_fetch;
    assign rv_stale = mem_rvalid_i & ~in_fetch;

    assign mem_req_o  = ~rst & in_fetch & ~redirect_i
                      & (int'(fifo_cnt) + int'(outst_q) < DEPTH)
                      & (int'(outst_q) < MAX_OUTST);
    assign mem_addr_o = fetch_pc_q;
    assign acc        = mem_req_o & mem_gnt_i;

`ifdef PREFETCH_BYPASS_EN
    assign byp = fifo_empty & rv_live & ~redirect_i;
`else
    assign byp = 1'b0;
`endif

    // rsp_pc_q is the PC of the oldest outstanding request, so it labels the next live response.
    assign fifo_wdat = '{pc: rsp_pc_q, inst: mem_rdata_i};
    assign fifo_wr   = rv_live & ~redirect_i & ~(byp & deq_i) & (~fifo_full | fifo_rd);
    assign fifo_rd   = deq_i & ~fifo_empty & ~redirect_i;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (redirect_i),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (fifo_wdat),
        .rd_en_i  (fifo_rd),
        .rd_dat_o (fifo_head),
        .count_o  (fifo_cnt),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign head          = byp ? fifo_wdat : fifo_head;
    assign inst_valid_o  = ~fifo_empty | byp;
    assign inst_o        = head.inst;
    assign inst_pc_o     = head.pc;
    assign inst_pcplus_o = inst_valid_o ? head.pc + PC_STEP : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        stale_d    = stale_q;
        if (acc)      fetch_pc_d = fetch_pc_q + PC_STEP;
        if (rv_live)  rsp_pc_d   = rsp_pc_q + PC_STEP;
        if (rv_stale) stale_d    = stale_q - CNT_W'(1);
        outst_d = outst_q + CNT_W'(acc) - CNT_W'(rv_live);
        // Whatever is still in flight after this edge can only come back as garbage.
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc_i[31:2], 2'b00};
            stale_d    = stale_d + outst_d;
            outst_d    = '0;
        end
        state_d = (stale_d != '0) ? ST_DRAIN : ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            stale_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
        end
    end

endmodule
